// File: rtl/bit_serializer_pkg.sv
// Shared definitions for bit_serializer: state encoding and default word width.
// The SER_PARITY_EN macro (even-parity slot after each word) is left undefined by default.
package bit_serializer_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    localparam int unsigned SER_W = 8;

    typedef enum logic {
        StIdle  = ST_IDLE,
        StShift = ST_SHIFT
    } ser_state_e;

endpackage

// File: rtl/bit_serializer.sv
// Double-buffered parallel-to-serial front end, MSB first, paced by bit_en.
// Define SER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned W = SER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    input  logic         bit_en,
    output logic         dout,
    output logic         dout_valid,
    output logic         busy,
    output logic         word_done
);

`ifdef SER_PARITY_EN
    localparam int unsigned CW   = $clog2(W + 2);
    localparam int unsigned LAST = W;
`else
    localparam int unsigned CW   = $clog2(W + 1);
    localparam int unsigned LAST = W - 1;
`endif
    localparam logic [CW-1:0] LastCnt = CW'(LAST);

    ser_state_e    state_q, state_d;
    logic [W-1:0]  hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          word_done_q, word_done_d;
    logic          load;
`ifdef SER_PARITY_EN
    logic          par_q, par_d;
`endif

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        word_done_d = 1'b0;
        load        = 1'b0;
`ifdef SER_PARITY_EN
        par_d       = par_q;
`endif

        // Accept only into an empty holding register, so it never collides with a reload.
        if (in_valid && !hold_full_q) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (bit_en) begin
                    if (cnt_q == LastCnt) begin
                        word_done_d = 1'b1;
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        shift_d = {shift_q[W-2:0], 1'b0};
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            cnt_d       = '0;
`ifdef SER_PARITY_EN
            par_d       = ^hold_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            word_done_q <= 1'b0;
`ifdef SER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            word_done_q <= word_done_d;
`ifdef SER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign in_ready   = ~hold_full_q;
    assign dout_valid = (state_q == StShift);
    assign busy       = (state_q == StShift) || hold_full_q;
    assign word_done  = word_done_q;
`ifdef SER_PARITY_EN
    // Once all data bits are out, the slot at count W carries the latched parity.
    assign dout = (state_q == StShift) && ((cnt_q == CW'(W)) ? par_q : shift_q[W-1]);
`else
    assign dout = (state_q == StShift) && shift_q[W-1];
`endif

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer; honours SER_PARITY_EN for expected streams.
module tb_bit_serializer;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         bit_en = 1'b0;
    logic         in_ready, dout, dout_valid, busy, word_done;

    int tests = 0;
    int fails = 0;

    // Capture results of one run_words call.
    logic [63:0]  bits;
    int           nbits, nvalid, fv, lv, acc0, ndone, ready_low;
    int           done_at[4];
    logic [W-1:0] wq[4];

    bit_serializer #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .bit_en     (bit_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .word_done  (word_done)
    );

    always #5 clk = ~clk;

    // Upstream source plus serial sink: presents wq[0..nw-1] with valid/ready, drives bit_en
    // (every cycle for period 1, else every period-th valid cycle) and records retired bits.
    task automatic run_words(input int nw, input int period, input int ncyc);
        int head = 0;
        bit sent = 1'b0;
        int vcount = 0;
        bits = '0; nbits = 0; nvalid = 0; fv = -1; lv = -1; acc0 = -1; ndone = 0; ready_low = 0;
        for (int k = 0; k < 4; k++) done_at[k] = -100;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (sent) head++;
            if (word_done && ndone < 4) begin
                done_at[ndone] = i;
                ndone++;
            end
            if (!in_ready) ready_low++;
            if (dout_valid) begin
                nvalid++;
                vcount++;
                if (fv < 0) fv = i;
                lv = i;
            end
            bit_en = (period == 1) ? 1'b1 : (dout_valid && (vcount % period == 0));
            if (dout_valid && bit_en) begin
                bits = {bits[62:0], dout};
                nbits++;
            end
            in_valid = (head < nw);
            in_data  = (head < nw) ? wq[head] : '0;
            sent = in_valid && in_ready;
            if (sent && acc0 < 0) acc0 = i;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        tests++; if (dout !== 1'b0) begin fails++; $display("FAIL reset_dout: got %b want 0", dout); end
        tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests++; if (word_done !== 1'b0) begin fails++; $display("FAIL reset_word_done: got %b want 0", word_done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single(input logic [W-1:0] w, input logic [NB-1:0] exp, input string nm);
        wq[0] = w;
        run_words(1, 1, 14);
        tests++; if (bits[NB-1:0] !== exp) begin fails++; $display("FAIL %s_bits: got %h want %h", nm, bits[NB-1:0], exp); end
        tests++; if (nbits !== NB) begin fails++; $display("FAIL %s_nbits: got %0d want %0d", nm, nbits, NB); end
        tests++; if (fv !== acc0 + 2) begin fails++; $display("FAIL %s_latency: first bit %0d want %0d", nm, fv, acc0 + 2); end
        tests++; if (ndone !== 1 || done_at[0] !== fv + NB) begin
            fails++; $display("FAIL %s_word_done: count %0d at %0d want 1 at %0d", nm, ndone, done_at[0], fv + NB);
        end
        tests++; if (nvalid !== NB) begin fails++; $display("FAIL %s_nvalid: got %0d want %0d", nm, nvalid, NB); end
        tests++; if (busy !== 1'b0 || dout_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL %s_end_idle: busy %b dout_valid %b in_ready %b want 0 0 1", nm, busy, dout_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*NB-1:0] exp;
`ifdef SER_PARITY_EN
        exp = {8'hDD, 1'b0, 8'hB6, 1'b1};
`else
        exp = {8'hDD, 8'hB6};
`endif
        wq[0] = 8'hDD; wq[1] = 8'hB6;
        run_words(2, 1, 26);
        tests++; if (bits[2*NB-1:0] !== exp) begin fails++; $display("FAIL b2b_bits: got %h want %h", bits[2*NB-1:0], exp); end
        tests++; if (nvalid !== 2 * NB || lv - fv + 1 !== nvalid) begin
            fails++; $display("FAIL b2b_contiguous: valid %0d span %0d want %0d", nvalid, lv - fv + 1, 2 * NB);
        end
        tests++; if (ndone !== 2 || done_at[1] - done_at[0] !== NB) begin
            fails++; $display("FAIL b2b_word_done: count %0d spacing %0d want 2 %0d", ndone, done_at[1] - done_at[0], NB);
        end
        tests++; if (ready_low == 0) begin fails++; $display("FAIL b2b_in_ready_drop: low cycles %0d want >0", ready_low); end
    endtask

    task automatic test_throttled();
        logic [NB-1:0] exp;
`ifdef SER_PARITY_EN
        exp = {8'hA5, 1'b0};
`else
        exp = 8'hA5;
`endif
        wq[0] = 8'hA5;
        run_words(1, 3, 36);
        tests++; if (bits[NB-1:0] !== exp) begin fails++; $display("FAIL thr_bits: got %h want %h", bits[NB-1:0], exp); end
        tests++; if (nvalid !== 3 * NB || lv - fv + 1 !== nvalid) begin
            fails++; $display("FAIL thr_valid_cycles: valid %0d span %0d want %0d", nvalid, lv - fv + 1, 3 * NB);
        end
        tests++; if (ndone !== 1 || done_at[0] !== fv + 3 * NB) begin
            fails++; $display("FAIL thr_word_done: count %0d at %0d want 1 at %0d", ndone, done_at[0], fv + 3 * NB);
        end
    endtask

    task automatic test_backpressure();
        logic [3*NB-1:0] exp;
`ifdef SER_PARITY_EN
        exp = {8'h3C, 1'b0, 8'h81, 1'b0, 8'hFF, 1'b0};
`else
        exp = {8'h3C, 8'h81, 8'hFF};
`endif
        wq[0] = 8'h3C; wq[1] = 8'h81; wq[2] = 8'hFF;
        run_words(3, 1, 34);
        tests++; if (bits[3*NB-1:0] !== exp) begin fails++; $display("FAIL bp_bits: got %h want %h", bits[3*NB-1:0], exp); end
        tests++; if (nvalid !== 3 * NB || lv - fv + 1 !== nvalid) begin
            fails++; $display("FAIL bp_contiguous: valid %0d span %0d want %0d", nvalid, lv - fv + 1, 3 * NB);
        end
        tests++; if (ndone !== 3 || done_at[2] - done_at[1] !== NB) begin
            fails++; $display("FAIL bp_word_done: count %0d spacing %0d want 3 %0d", ndone, done_at[2] - done_at[1], NB);
        end
        tests++; if (ready_low < NB) begin fails++; $display("FAIL bp_in_ready_low: low cycles %0d want >=%0d", ready_low, NB); end
    endtask

    task automatic test_reset_midword();
        logic [NB-1:0] exp;
`ifdef SER_PARITY_EN
        exp = {8'hD0, 1'b1};
`else
        exp = 8'hD0;
`endif
        wq[0] = 8'hD0; wq[1] = 8'hFF;
        run_words(2, 1, 5);
        @(posedge clk);
        #1;
        tests++; if (dout !== 1'b1 || dout_valid !== 1'b1 || nbits !== 3) begin
            fails++; $display("FAIL mid_pre: dout %b valid %b retired %0d want 1 1 3", dout, dout_valid, nbits);
        end
        #1 rst_n = 1'b0;
        #1;
        tests++; if (dout !== 1'b0 || dout_valid !== 1'b0) begin
            fails++; $display("FAIL mid_async_out: dout %b valid %b want 0 0", dout, dout_valid);
        end
        tests++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL mid_async_hold: busy %b in_ready %b want 0 1", busy, in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (busy !== 1'b0 || dout_valid !== 1'b0) begin
            fails++; $display("FAIL mid_held_discarded: busy %b valid %b want 0 0", busy, dout_valid);
        end
        wq[0] = 8'hD0;
        run_words(1, 1, 14);
        tests++; if (bits[NB-1:0] !== exp || fv !== acc0 + 2) begin
            fails++; $display("FAIL mid_restart: bits %h first %0d want %h %0d", bits[NB-1:0], fv, exp, acc0 + 2);
        end
    endtask

    initial begin
        test_reset();
`ifdef SER_PARITY_EN
        test_single(8'hD0, {8'hD0, 1'b1}, "d0");
        test_single(8'hC0, {8'hC0, 1'b0}, "c0");
`else
        test_single(8'hD0, 8'hD0, "d0");
        test_single(8'h01, 8'h01, "lsb");
`endif
        test_back_to_back();
        test_throttled();
        test_backpressure();
        test_reset_midword();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
